// File: rtl/gate_identifier.sv
`default_nettype none
// gate_identifier: drives all four (a,b) vectors into an external two-input gate,
// samples its output into a 4-bit truth table and decodes the gate type. Rev 1.0
module gate_identifier #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] gate_code,
  output logic       gate_valid
);

  // Counter must reach SETTLE_CYCLES without wrapping; keep at least one bit.
  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_idx;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      w_code;
  logic            w_valid;

  always_comb begin
    w_code  = 3'd7;
    w_valid = 1'b1;
    case (truth_table)
      4'b1000: w_code = 3'd0;
      4'b1110: w_code = 3'd1;
      4'b0111: w_code = 3'd2;
      4'b0001: w_code = 3'd3;
      4'b0110: w_code = 3'd4;
      4'b1001: w_code = 3'd5;
      4'b0011: w_code = 3'd6;
      default: begin
        w_code  = 3'd7;
        w_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= '0;
      a_out       <= 1'b0;
      b_out       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= 4'd0;
      gate_code   <= 3'd0;
      gate_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_APPLY;
            busy        <= 1'b1;
            r_idx       <= 2'd0;
            r_cnt       <= '0;
            a_out       <= 1'b0;
            b_out       <= 1'b0;
            gate_valid  <= 1'b0;
            truth_table <= 4'd0;
          end
        end
        S_APPLY: begin
          if (r_cnt == C_LAST) begin
            // Final edge of this vector's hold: the only point y_in is observed.
            truth_table[r_idx] <= y_in;
            r_cnt              <= '0;
            if (r_idx == 2'd3) begin
              r_state <= S_DECODE;
            end else begin
              r_idx          <= r_idx + 2'd1;
              {a_out, b_out} <= r_idx + 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          gate_code  <= w_code;
          gate_valid <= w_valid;
          a_out      <= 1'b0;
          b_out      <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_identifier.sv
`default_nettype none
// tb_gate_identifier: scoreboard bench driving two instances (SETTLE_CYCLES=0 and 1)
// with behavioural gate models on y_in.
module tb_gate_identifier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic st0 = 1'b0, st1 = 1'b0;
  logic y0, y1, gl1 = 1'b0;
  logic a0, b0, busy0, done0, valid0, a1, b1, busy1, done1, valid1;
  logic [3:0] tt0, tt1;
  logic [2:0] code0, code1;

  int kind0 = 7, kind1 = 7;
  logic [3:0] rt0 = 4'd0, rt1 = 4'd0;
  int cyc = 0;
  int acc1 = -100;
  int checks = 0, failures = 0;
  int NN [2] = '{5, 9};

  typedef struct {
    logic [3:0] tt;
    logic [2:0] code;
    logic       valid;
    int         dcyc;
  } exp_t;
  exp_t q0[$], q1[$];
  bit eb0[int], eb1[int];

  // Gate models described by their boolean function, not by a table.
  function automatic logic gate_y(input int k, input logic a, input logic b, input logic [3:0] rt);
    case (k)
      0: return a & b;
      1: return a | b;
      2: return ~(a & b);
      3: return ~(a | b);
      4: return a ^ b;
      5: return ~(a ^ b);
      6: return ~a;
      8: return rt[{a, b}];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_code(input logic [3:0] t);
    logic [3:0] known [7];
    known = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011};
    for (int i = 0; i < 7; i++)
      if (known[i] == t) return 3'(i);
    return 3'd7;
  endfunction

  assign y0 = gate_y(kind0, a0, b0, rt0);
  assign y1 = gate_y(kind1, a1, b1, rt1) ^ gl1;

  gate_identifier #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .y_in(y0), .a_out(a0), .b_out(b0),
    .busy(busy0), .done(done0), .truth_table(tt0), .gate_code(code0), .gate_valid(valid0)
  );
  gate_identifier #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .y_in(y1), .a_out(a1), .b_out(b1),
    .busy(busy1), .done(done1), .truth_table(tt1), .gate_code(code1), .gate_valid(valid1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Glitch y_in on the non-sampling edges of the slow instance.
  always @(posedge clk) begin
    int r;
    #2;
    r = cyc + 1 - acc1;
    gl1 = (r >= 1 && r <= 8 && (r % 2) == 1) ? 1'($urandom % 2) : 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push_run(input int d, input int k, input logic [3:0] rt, input int acc);
    exp_t e;
    logic [3:0] t;
    logic [1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      t[i] = gate_y(k, v[1], v[0], rt);
    end
    e.tt = t;
    e.code = exp_code(t);
    e.valid = (e.code != 3'd7);
    e.dcyc = acc + NN[d];
    if (d == 0) begin
      kind0 = k; rt0 = rt; q0.push_back(e);
      for (int c = acc; c < acc + NN[d]; c++) eb0[c] = 1'b1;
    end else begin
      kind1 = k; rt1 = rt; acc1 = acc; q1.push_back(e);
      for (int c = acc; c < acc + NN[d]; c++) eb1[c] = 1'b1;
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) st0 = v; else st1 = v;
  endtask

  task automatic launch(input int d, input int k, input logic [3:0] rt, output int acc);
    acc = cyc + 1;
    push_run(d, k, rt, acc);
    set_start(d, 1'b1);
    @(posedge clk); #1;
    set_start(d, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon(input int d, input logic dn, input logic [3:0] tt, input logic [2:0] code,
                     input logic v, input logic bz);
    exp_t e;
    bit have;
    string p;
    p = $sformatf("d%0d_", d);
    chk({p, "busy"}, 32'(bz), (d == 0) ? 32'(eb0.exists(cyc)) : 32'(eb1.exists(cyc)));
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) begin
      e = (d == 0) ? q0[0] : q1[0];
      if (e.dcyc < cyc) begin
        checks++; failures++;
        $display("FAIL %smissing_done: no done by cyc %0d, required at %0d", p, cyc, e.dcyc);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        have = 1'b0;
      end
    end
    if (dn === 1'b1) begin
      if (!have) begin
        checks++; failures++;
        $display("FAIL %sunexpected_done: done=1 at cyc %0d, required none", p, cyc);
      end else begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk({p, "done_cycle"}, 32'(cyc), 32'(e.dcyc));
        chk({p, "truth_table"}, 32'(tt), 32'(e.tt));
        chk({p, "gate_code"}, 32'(code), 32'(e.code));
        chk({p, "gate_valid"}, 32'(v), 32'(e.valid));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, done0, tt0, code0, valid0, busy0);
    mon(1, done1, tt1, code1, valid1, busy1);
  end

  initial begin
    int acc, d, k;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", 32'(a1), 0);        chk("rst_b", 32'(b1), 0);
    chk("rst_busy", 32'(busy1), 0);  chk("rst_done", 32'(done1), 0);
    chk("rst_tt", 32'(tt1), 0);      chk("rst_code", 32'(code1), 0);
    chk("rst_valid", 32'(valid1), 0); chk("rst_tt0", 32'(tt0), 0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    launch(1, 0, 4'd0, acc); idle(11);             // AND, settle 1
    launch(0, 4, 4'd0, acc); idle(16);             // XOR, settle 0, then hold
    chk("xor_hold_code", 32'(code0), 4);
    chk("xor_hold_valid", 32'(valid0), 1);
    launch(1, 7, 4'd0, acc); idle(11);             // stuck-at-0
    launch(1, 6, 4'd0, acc); idle(11);             // NOT a

    launch(1, 3, 4'd0, acc);                       // NOR with ignored starts at edges 2, 4
    idle(0);
    @(posedge clk); #1 st1 = 1'b1;
    @(posedge clk); #1 st1 = 1'b0;
    @(posedge clk); #1 st1 = 1'b1;
    @(posedge clk); #1 st1 = 1'b0;
    idle(8);

    launch(1, 0, 4'd0, acc);                       // abort via reset after edge 3
    idle(3);
    rst_n = 1'b0;
    #1;
    q1.delete(); eb1.delete(); q0.delete(); eb0.delete();
    chk("abort_a", 32'(a1), 0);       chk("abort_b", 32'(b1), 0);
    chk("abort_busy", 32'(busy1), 0); chk("abort_done", 32'(done1), 0);
    chk("abort_tt", 32'(tt1), 0);     chk("abort_code", 32'(code1), 0);
    chk("abort_valid", 32'(valid1), 0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    launch(1, 5, 4'd0, acc); idle(11);             // XNOR after recovery

    for (int dd = 1; dd >= 0; dd--) begin          // back-to-back via held start
      acc = cyc + 1;
      push_run(dd, 1, 4'd0, acc);
      set_start(dd, 1'b1);
      idle(NN[dd] + 1);
      push_run(dd, 2, 4'd0, acc + NN[dd] + 1);
      idle(1);
      set_start(dd, 1'b0);
      chk($sformatf("d%0d_b2b_valid_clr", dd), 32'((dd == 0) ? valid0 : valid1), 0);
      chk($sformatf("d%0d_b2b_tt_clr", dd), 32'((dd == 0) ? tt0 : tt1), 0);
      idle(NN[dd] + 2);
    end

    for (int n = 0; n < 20; n++) begin             // random gates and tables
      d = int'($urandom % 2);
      k = int'($urandom % 9);
      launch(d, k, 4'($urandom), acc);
      idle(NN[d] + 1 + int'($urandom % 3));
    end

    idle(12);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
